// File: rtl/eq_band_sequencer.sv
// Time-multiplexes one external POT-squared band scaler across NUM_BANDS equalizer
// bands, accumulating the scaled bands into a saturated 16-bit output sample.
module eq_band_sequencer #(
    parameter int unsigned NUM_BANDS = 5,
    parameter int unsigned IDX_W     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld,
    input  logic [16*NUM_BANDS-1:0]   band_audio,
    input  logic [12*NUM_BANDS-1:0]   band_POT,
    output logic [11:0]               scl_POT,
    output logic [15:0]               scl_audio,
    input  logic [15:0]               scl_scaled,
    output logic [15:0]               aud_out,
    output logic                      out_vld,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned ACC_W  = 16 + $clog2(NUM_BANDS);
    localparam int unsigned EXT_W  = ACC_W - 16;
    localparam int unsigned HEAD_W = ACC_W - 15;

    typedef enum logic {
        IDLE,
        SCALE
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_d;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] sum;
    logic [15:0]             sat_val;
    logic [15:0]             aud_out_d;
    logic                    out_vld_d;
    logic                    overrun_d;
    logic                    latch_en;
    logic                    last;
    logic [HEAD_W-1:0]       sum_head;

    logic [15:0]             aud_lat [NUM_BANDS];
    logic [11:0]             pot_lat [NUM_BANDS];
    logic [15:0]             sel_audio;
    logic [11:0]             sel_pot;

    // Select the latched band for the current step
    always_comb begin
        sel_audio = '0;
        sel_pot   = '0;
        for (int i = 0; i < int'(NUM_BANDS); i++) begin
            if (idx == IDX_W'(i)) begin
                sel_audio = aud_lat[i];
                sel_pot   = pot_lat[i];
            end
        end
    end

    assign busy      = (state == SCALE);
    assign scl_audio = busy ? sel_audio : 16'h0000;
    assign scl_POT   = busy ? sel_pot   : 12'h000;
    assign last      = (idx == IDX_W'(NUM_BANDS - 1));

    assign sum      = acc + {{EXT_W{scl_scaled[15]}}, scl_scaled};
    assign sum_head = sum[ACC_W-1:15];

    // Clamp to 16 bits when the bits above the sign bit disagree
    always_comb begin
        if ((&sum_head) || (~|sum_head)) begin
            sat_val = sum[15:0];
        end else if (sum[ACC_W-1]) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = 16'h7FFF;
        end
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        acc_d     = acc;
        aud_out_d = aud_out;
        out_vld_d = 1'b0;
        overrun_d = 1'b0;
        latch_en  = 1'b0;
        case (state)
            IDLE: begin
                if (vld) begin
                    latch_en = 1'b1;
                    idx_d    = '0;
                    acc_d    = '0;
                    state_d  = SCALE;
                end
            end
            SCALE: begin
                overrun_d = vld;
                acc_d     = sum;
                idx_d     = idx + IDX_W'(1);
                if (last) begin
                    aud_out_d = sat_val;
                    out_vld_d = 1'b1;
                    idx_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            acc     <= '0;
            aud_out <= '0;
            out_vld <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < int'(NUM_BANDS); i++) begin
                aud_lat[i] <= '0;
                pot_lat[i] <= '0;
            end
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            acc     <= acc_d;
            aud_out <= aud_out_d;
            out_vld <= out_vld_d;
            overrun <= overrun_d;
            if (latch_en) begin
                for (int i = 0; i < int'(NUM_BANDS); i++) begin
                    aud_lat[i] <= band_audio[16*i +: 16];
                    pot_lat[i] <= band_POT[12*i +: 12];
                end
            end
        end
    end

endmodule

// File: tb/tb_eq_band_sequencer.sv
// Directed bench for eq_band_sequencer with a behavioural POT-squared scaler model.
module tb_eq_band_sequencer;

    localparam int unsigned NB = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              vld;
    logic [16*NB-1:0]  band_audio;
    logic [12*NB-1:0]  band_POT;
    logic [11:0]       scl_POT;
    logic [15:0]       scl_audio;
    logic [15:0]       scl_scaled;
    logic [15:0]       aud_out;
    logic              out_vld;
    logic              busy;
    logic              overrun;

    eq_band_sequencer #(.NUM_BANDS(NB), .IDX_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .vld        (vld),
        .band_audio (band_audio),
        .band_POT   (band_POT),
        .scl_POT    (scl_POT),
        .scl_audio  (scl_audio),
        .scl_scaled (scl_scaled),
        .aud_out    (aud_out),
        .out_vld    (out_vld),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Scaler model: audio * POT^2 / 2^22, so POT=0x800 is unity gain
    longint sa, sp, sr;
    always_comb begin
        sa = longint'(signed'(scl_audio));
        sp = longint'(scl_POT);
        sr = (sa * sp * sp) >>> 22;
        if (sr > 32767)
            scl_scaled = 16'h7FFF;
        else if (sr < -32768)
            scl_scaled = 16'h8000;
        else
            scl_scaled = 16'(sr);
    end

    typedef struct {
        string               name;
        logic [NB-1:0][15:0] audio;
        logic [NB-1:0][11:0] pot;
        logic [15:0]         exp_out;
    } vec_t;

    vec_t vecs [5];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        band_audio = v.audio;
        band_POT   = v.pot;
    endtask

    // Count cycles from the negedge after the latch edge until out_vld, bounded
    task automatic wait_out(output int n);
        n = 0;
        while (!out_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Full transaction: band stepping, latency, result, pulse width
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            chk({v.name, " busy"}, 32'(busy), 32'd1);
            chk({v.name, " scl_audio"}, 32'(scl_audio), 32'(v.audio[i]));
            chk({v.name, " scl_POT"}, 32'(scl_POT), 32'(v.pot[i]));
            @(negedge clk);
        end
        chk({v.name, " out_vld"}, 32'(out_vld), 32'd1);
        chk({v.name, " aud_out"}, 32'(aud_out), 32'(v.exp_out));
        chk({v.name, " busy_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({v.name, " out_vld_pulse"}, 32'(out_vld), 32'd0);
    endtask

    int n;
    int pulses;

    initial begin
        vecs[0].name = "unity";
        vecs[0].audio[0] = 16'd1000;
        vecs[0].audio[1] = 16'd2000;
        vecs[0].audio[2] = 16'hFE0C;
        vecs[0].audio[3] = 16'd300;
        vecs[0].audio[4] = 16'hFF9C;
        for (int i = 0; i < int'(NB); i++) vecs[0].pot[i] = 12'h800;
        vecs[0].exp_out = 16'h0A8C;

        vecs[1].name = "max_gain";
        for (int i = 0; i < int'(NB); i++) begin
            vecs[1].audio[i] = 16'h0100;
            vecs[1].pot[i]   = 12'hFFF;
        end
        vecs[1].exp_out = 16'h13FB;

        vecs[2].name = "sat_pos";
        for (int i = 0; i < int'(NB); i++) begin
            vecs[2].audio[i] = 16'h7000;
            vecs[2].pot[i]   = 12'h800;
        end
        vecs[2].exp_out = 16'h7FFF;

        vecs[3].name = "sat_neg";
        for (int i = 0; i < int'(NB); i++) begin
            vecs[3].audio[i] = 16'h9000;
            vecs[3].pot[i]   = 12'h800;
        end
        vecs[3].exp_out = 16'h8000;

        vecs[4].name = "pot_zero";
        for (int i = 0; i < int'(NB); i++) begin
            vecs[4].audio[i] = 16'h0000;
            vecs[4].pot[i]   = 12'h800;
        end
        vecs[4].audio[2] = 16'h7FFF;
        vecs[4].pot[2]   = 12'h000;
        vecs[4].exp_out  = 16'h0000;

        rst = 1'b1;
        vld = 1'b0;
        band_audio = '0;
        band_POT   = '0;
        repeat (2) @(negedge clk);
        chk("rst aud_out", 32'(aud_out), 32'd0);
        chk("rst out_vld", 32'(out_vld), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        chk("rst scl_POT", 32'(scl_POT), 32'd0);
        chk("rst scl_audio", 32'(scl_audio), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // Overrun: second strobe two edges after the first, inputs changed after latch
        @(negedge clk);
        drive(vecs[0]);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        drive(vecs[1]);
        @(negedge clk);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        chk("ovr overrun_pulse", 32'(overrun), 32'd1);
        @(negedge clk);
        chk("ovr overrun_clear", 32'(overrun), 32'd0);
        repeat (2) @(negedge clk);
        chk("ovr out_vld", 32'(out_vld), 32'd1);
        chk("ovr aud_out", 32'(aud_out), 32'h0A8C);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_vld) pulses++;
        end
        chk("ovr no_second_out", 32'(pulses), 32'd0);

        // Back-to-back: new strobe in the cycle out_vld is high
        @(negedge clk);
        drive(vecs[0]);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        wait_out(n);
        chk("b2b first_latency", 32'(n), 32'd5);
        chk("b2b first_aud_out", 32'(aud_out), 32'h0A8C);
        drive(vecs[1]);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        chk("b2b overrun", 32'(overrun), 32'd0);
        chk("b2b busy", 32'(busy), 32'd1);
        wait_out(n);
        chk("b2b second_latency", 32'(n), 32'd5);
        chk("b2b second_aud_out", 32'(aud_out), 32'h13FB);

        // Reset during SCALE aborts the set and clears aud_out
        @(negedge clk);
        drive(vecs[0]);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst busy", 32'(busy), 32'd0);
        chk("mid_rst aud_out", 32'(aud_out), 32'd0);
        chk("mid_rst out_vld", 32'(out_vld), 32'd0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_vld) pulses++;
        end
        chk("mid_rst no_out", 32'(pulses), 32'd0);
        run_vec(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
